// File: rtl/decode_stage_p.sv
// -----------------------------------------------------------------------------
// decode_stage_p
//
// Decode stage of a five-stage MIPS-style pipeline. It holds the IF/ID
// pipeline register, the architectural register file and the early branch
// and jump resolution logic, so a taken control transfer is known one cycle
// after the instruction is fetched.
//
// Parameters
//   XLEN      datapath width (32 or more)
//   NREG      register count, a power of two from 8 to 32
//   LINK_REG  register written by jal (defaults to the top register)
//
// Ports
//   clk          rising-edge clock
//   reset        synchronous, active-high; clears IF/ID and the register file
//   stall_d      hold the IF/ID register
//   flush_d      load a bubble into the IF/ID register
//   pc_plus_4_f  fetch-stage PC+4
//   instr_f      fetched instruction
//   wb_we        writeback enable
//   wb_addr      writeback register number (RW bits)
//   wb_data      writeback value
//   fwd_a_d      rs operand source: 00 regfile, 01 alu_out_m, 10 wb_data,
//                11 reserved (regfile)
//   fwd_b_d      rt operand source, same encoding
//   alu_out_m    memory-stage ALU result
//   valid_d      IF/ID holds a real instruction
//   instr_d      registered instruction
//   pc_plus_4_d  registered PC+4
//   rs_d/rt_d/rd_d  instruction register fields
//   rd1_d/rd2_d  forwarded operand values
//   imm_ext_d    sign-extended 16-bit immediate
//   pcsrc_d      redirect fetch this cycle
//   pc_next_d    redirect target, meaningful only when pcsrc_d=1
// -----------------------------------------------------------------------------
module decode_stage_p #(
  parameter int XLEN     = 32,
  parameter int NREG     = 32,
  parameter int LINK_REG = NREG - 1,
  localparam int RW      = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall_d,
  input  logic            flush_d,
  input  logic [XLEN-1:0] pc_plus_4_f,
  input  logic [31:0]     instr_f,
  input  logic            wb_we,
  input  logic [RW-1:0]   wb_addr,
  input  logic [XLEN-1:0] wb_data,
  input  logic [1:0]      fwd_a_d,
  input  logic [1:0]      fwd_b_d,
  input  logic [XLEN-1:0] alu_out_m,
  output logic            valid_d,
  output logic [31:0]     instr_d,
  output logic [XLEN-1:0] pc_plus_4_d,
  output logic [4:0]      rs_d,
  output logic [4:0]      rt_d,
  output logic [4:0]      rd_d,
  output logic [XLEN-1:0] rd1_d,
  output logic [XLEN-1:0] rd2_d,
  output logic [XLEN-1:0] imm_ext_d,
  output logic            pcsrc_d,
  output logic [XLEN-1:0] pc_next_d
);

  localparam logic [RW-1:0] LINK_A = RW'(LINK_REG);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] FN_JR    = 6'b001000;

  localparam logic [1:0] FWD_ALU_M = 2'b01;
  localparam logic [1:0] FWD_WB    = 2'b10;

  // Write-first read: the link port has priority over the writeback port,
  // mirroring the write priority at the clock edge. Register 0 is hardwired.
  function automatic logic [XLEN-1:0] rf_bypass(
    input logic [RW-1:0]   ra,
    input logic [XLEN-1:0] stored,
    input logic            l_we,
    input logic [XLEN-1:0] l_data,
    input logic            w_we,
    input logic [RW-1:0]   w_addr,
    input logic [XLEN-1:0] w_data
  );
    logic [XLEN-1:0] val;
    val = stored;
    if (ra == '0)
      val = '0;
    else if (l_we && (ra == LINK_A))
      val = l_data;
    else if (w_we && (ra == w_addr))
      val = w_data;
    return val;
  endfunction

  // Operand forwarding; the reserved code falls back to the register file.
  function automatic logic [XLEN-1:0] fwd_mux(
    input logic [1:0]      sel,
    input logic [XLEN-1:0] rf_val,
    input logic [XLEN-1:0] alu_m,
    input logic [XLEN-1:0] wb_val
  );
    logic [XLEN-1:0] val;
    case (sel)
      FWD_ALU_M: val = alu_m;
      FWD_WB:    val = wb_val;
      default:   val = rf_val;
    endcase
    return val;
  endfunction

  // ---------------------------------------------------------------------------
  // Stage p1: IF/ID pipeline register (reset > flush > stall > load)
  // ---------------------------------------------------------------------------
  logic            vld_p1;
  logic [31:0]     instr_p1;
  logic [XLEN-1:0] pc4_p1;

  always_ff @(posedge clk) begin
    if (reset || flush_d) begin
      vld_p1   <= 1'b0;
      instr_p1 <= '0;
      pc4_p1   <= '0;
    end else if (!stall_d) begin
      vld_p1   <= 1'b1;
      instr_p1 <= instr_f;
      pc4_p1   <= pc_plus_4_f;
    end
  end

  assign valid_d     = vld_p1;
  assign instr_d     = instr_p1;
  assign pc_plus_4_d = pc4_p1;
  assign rs_d        = instr_p1[25:21];
  assign rt_d        = instr_p1[20:16];
  assign rd_d        = instr_p1[15:11];

  // ---------------------------------------------------------------------------
  // Decode of the held instruction
  // ---------------------------------------------------------------------------
  logic [5:0] op_p1;
  logic [5:0] funct_p1;
  logic       is_beq_p1;
  logic       is_bne_p1;
  logic       is_j_p1;
  logic       is_jal_p1;
  logic       is_jr_p1;

  assign op_p1     = instr_p1[31:26];
  assign funct_p1  = instr_p1[5:0];
  assign is_beq_p1 = (op_p1 == OP_BEQ);
  assign is_bne_p1 = (op_p1 == OP_BNE);
  assign is_j_p1   = (op_p1 == OP_J);
  assign is_jal_p1 = (op_p1 == OP_JAL);
  assign is_jr_p1  = (op_p1 == OP_RTYPE) && (funct_p1 == FN_JR);

  // ---------------------------------------------------------------------------
  // Register file: write port W (writeback) and port L (jal link)
  // ---------------------------------------------------------------------------
  logic [XLEN-1:0] rf_q [NREG];
  logic            wb_wr;
  logic            link_wr;
  logic [XLEN-1:0] link_data;

  // Both write ports are gated by reset so nothing presented during the
  // reset cycle lands in the file or shows up on the bypass path. The link
  // write waits for the stall to release so each jal links exactly once.
  assign wb_wr     = wb_we && !reset && (wb_addr != '0);
  assign link_wr   = vld_p1 && is_jal_p1 && !stall_d && !reset && (LINK_A != '0);
  assign link_data = pc4_p1 + XLEN'(4);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++)
        rf_q[i] <= '0;
    end else begin
      if (wb_wr)
        rf_q[wb_addr] <= wb_data;
      // Later assignment wins: link beats writeback on a collision.
      if (link_wr)
        rf_q[LINK_A] <= link_data;
    end
  end

  // Address bits above RW are ignored.
  logic [RW-1:0]   ra1;
  logic [RW-1:0]   ra2;
  logic [XLEN-1:0] rf_rd1;
  logic [XLEN-1:0] rf_rd2;

  assign ra1 = rs_d[RW-1:0];
  assign ra2 = rt_d[RW-1:0];

  assign rf_rd1 = rf_bypass(ra1, rf_q[ra1], link_wr, link_data, wb_wr, wb_addr, wb_data);
  assign rf_rd2 = rf_bypass(ra2, rf_q[ra2], link_wr, link_data, wb_wr, wb_addr, wb_data);

  assign rd1_d = fwd_mux(fwd_a_d, rf_rd1, alu_out_m, wb_data);
  assign rd2_d = fwd_mux(fwd_b_d, rf_rd2, alu_out_m, wb_data);

  // ---------------------------------------------------------------------------
  // Branch / jump resolution
  // ---------------------------------------------------------------------------
  logic signed [XLEN-1:0] imm_ext_s;
  logic signed [XLEN-1:0] imm_word_s;
  logic        [XLEN-1:0] branch_target;
  logic        [XLEN-1:0] jump_target;
  logic                   ops_equal;

  assign imm_ext_s     = {{(XLEN-16){instr_p1[15]}}, instr_p1[15:0]};
  assign imm_word_s    = imm_ext_s <<< 2;
  assign imm_ext_d     = imm_ext_s;
  assign branch_target = pc4_p1 + imm_word_s;
  // Pseudo-direct jump keeps the upper PC bits of the delay-slot region.
  assign jump_target   = {pc4_p1[XLEN-1:28], instr_p1[25:0], 2'b00};
  assign ops_equal     = (rd1_d == rd2_d);

  assign pcsrc_d = vld_p1 && ((is_beq_p1 && ops_equal) ||
                              (is_bne_p1 && !ops_equal) ||
                              is_j_p1 || is_jal_p1 || is_jr_p1);

  always_comb begin
    pc_next_d = branch_target;
    if (is_jr_p1)
      pc_next_d = rd1_d;
    else if (is_j_p1 || is_jal_p1)
      pc_next_d = jump_target;
  end

endmodule

// File: tb/tb_decode_stage_p.sv
module tb_decode_stage_p;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // 32-bit, 32-register instance
  logic        reset, stall_d, flush_d, wb_we;
  logic [31:0] pc_plus_4_f, instr_f, wb_data, alu_out_m;
  logic [4:0]  wb_addr;
  logic [1:0]  fwd_a_d, fwd_b_d;
  logic        valid_d, pcsrc_d;
  logic [31:0] instr_d, pc_plus_4_d, rd1_d, rd2_d, imm_ext_d, pc_next_d;
  logic [4:0]  rs_d, rt_d, rd_d;

  decode_stage_p dut (
    .clk(clk), .reset(reset), .stall_d(stall_d), .flush_d(flush_d),
    .pc_plus_4_f(pc_plus_4_f), .instr_f(instr_f),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .fwd_a_d(fwd_a_d), .fwd_b_d(fwd_b_d), .alu_out_m(alu_out_m),
    .valid_d(valid_d), .instr_d(instr_d), .pc_plus_4_d(pc_plus_4_d),
    .rs_d(rs_d), .rt_d(rt_d), .rd_d(rd_d), .rd1_d(rd1_d), .rd2_d(rd2_d),
    .imm_ext_d(imm_ext_d), .pcsrc_d(pcsrc_d), .pc_next_d(pc_next_d)
  );

  // 64-bit, 16-register instance
  logic        w_reset, w_stall_d, w_flush_d, w_wb_we;
  logic [63:0] w_pc_plus_4_f, w_wb_data, w_alu_out_m;
  logic [31:0] w_instr_f;
  logic [3:0]  w_wb_addr;
  logic [1:0]  w_fwd_a_d, w_fwd_b_d;
  logic        w_valid_d, w_pcsrc_d;
  logic [31:0] w_instr_d;
  logic [63:0] w_pc_plus_4_d, w_rd1_d, w_rd2_d, w_imm_ext_d, w_pc_next_d;
  logic [4:0]  w_rs_d, w_rt_d, w_rd_d;

  decode_stage_p #(.XLEN(64), .NREG(16)) dut_w (
    .clk(clk), .reset(w_reset), .stall_d(w_stall_d), .flush_d(w_flush_d),
    .pc_plus_4_f(w_pc_plus_4_f), .instr_f(w_instr_f),
    .wb_we(w_wb_we), .wb_addr(w_wb_addr), .wb_data(w_wb_data),
    .fwd_a_d(w_fwd_a_d), .fwd_b_d(w_fwd_b_d), .alu_out_m(w_alu_out_m),
    .valid_d(w_valid_d), .instr_d(w_instr_d), .pc_plus_4_d(w_pc_plus_4_d),
    .rs_d(w_rs_d), .rt_d(w_rt_d), .rd_d(w_rd_d), .rd1_d(w_rd1_d), .rd2_d(w_rd2_d),
    .imm_ext_d(w_imm_ext_d), .pcsrc_d(w_pcsrc_d), .pc_next_d(w_pc_next_d)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [31:0] instr, input logic [31:0] pc4);
    instr_f = instr; pc_plus_4_f = pc4; stall_d = 1'b0; flush_d = 1'b0;
    step();
  endtask

  task automatic wb_write(input logic [4:0] addr, input logic [31:0] data);
    wb_we = 1'b1; wb_addr = addr; wb_data = data;
    step();
    wb_we = 1'b0;
  endtask

  task automatic w_load(input logic [31:0] instr, input logic [63:0] pc4);
    w_instr_f = instr; w_pc_plus_4_f = pc4; w_stall_d = 1'b0; w_flush_d = 1'b0;
    step();
  endtask

  task automatic w_wb_write(input logic [3:0] addr, input logic [63:0] data);
    w_wb_we = 1'b1; w_wb_addr = addr; w_wb_data = data;
    step();
    w_wb_we = 1'b0;
  endtask

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc4;
    logic [1:0]  fa;
    logic [1:0]  fb;
    logic [31:0] alu;
    logic [31:0] wbd;
    logic        exp_pcsrc;
    logic [31:0] exp_next;
    logic [31:0] exp_rd1;
    logic [31:0] exp_rd2;
    logic [31:0] exp_imm;
  } vec_t;

  localparam int NVEC = 12;
  vec_t vecs [NVEC];

  // Fixed instruction words used by the hand-written sequences
  localparam logic [31:0] JAL_40    = {6'd3, 26'h40};
  localparam logic [31:0] JAL_RS31  = {6'd3, 5'd31, 21'd0};
  localparam logic [31:0] J_40      = {6'd2, 26'h40};
  localparam logic [31:0] READ_R31  = {6'd0, 5'd31, 21'd0};

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Register state when the table runs: r1=7, r5=0xDEADBEEF, others 0.
    //             instr                               pc4            fa    fb    alu        wbd       pcsrc next          rd1           rd2       imm
    vecs[0]  = '{{6'd4, 5'd1, 5'd2, 16'd3},           32'h100,       2'd0, 2'd1, 32'd7,     32'd0,    1'b1, 32'h10C,      32'd7,        32'd7,    32'd3};
    vecs[1]  = '{{6'd4, 5'd1, 5'd2, 16'd3},           32'h100,       2'd0, 2'd1, 32'd8,     32'd0,    1'b0, 32'h10C,      32'd7,        32'd8,    32'd3};
    vecs[2]  = '{{6'd5, 5'd1, 5'd2, 16'hFFFF},        32'h100,       2'd0, 2'd0, 32'd0,     32'd0,    1'b1, 32'hFC,       32'd7,        32'd0,    32'hFFFFFFFF};
    vecs[3]  = '{{6'd5, 5'd1, 5'd1, 16'd4},           32'h100,       2'd0, 2'd0, 32'd0,     32'd0,    1'b0, 32'h110,      32'd7,        32'd7,    32'd4};
    vecs[4]  = '{{6'd2, 26'h40},                      32'hA0002004,  2'd0, 2'd0, 32'd0,     32'd0,    1'b1, 32'hA0000100, 32'd0,        32'd0,    32'h40};
    vecs[5]  = '{{6'd0, 5'd5, 15'd0, 6'h08},          32'h100,       2'd0, 2'd0, 32'd0,     32'd0,    1'b1, 32'hDEADBEEF, 32'hDEADBEEF, 32'd0,    32'h8};
    vecs[6]  = '{{6'd0, 5'd5, 15'd0, 6'h08},          32'h100,       2'd2, 2'd0, 32'd0,     32'h1000, 1'b1, 32'h1000,     32'h1000,     32'd0,    32'h8};
    vecs[7]  = '{{6'd0, 5'd5, 15'd0, 6'h08},          32'h100,       2'd3, 2'd0, 32'h2222,  32'h1000, 1'b1, 32'hDEADBEEF, 32'hDEADBEEF, 32'd0,    32'h8};
    vecs[8]  = '{{6'd0, 5'd5, 5'd1, 5'd3, 5'd0, 6'h20}, 32'h100,     2'd0, 2'd0, 32'd0,     32'd0,    1'b0, 32'h6180,     32'hDEADBEEF, 32'd7,    32'h1820};
    vecs[9]  = '{{6'd4, 5'd1, 5'd2, 16'd3},           32'h100,       2'd1, 2'd0, 32'd0,     32'd0,    1'b1, 32'h10C,      32'd0,        32'd0,    32'd3};
    vecs[10] = '{{6'd4, 5'd1, 5'd2, 16'hFFFE},        32'h100,       2'd0, 2'd2, 32'd0,     32'd7,    1'b1, 32'hF8,       32'd7,        32'd7,    32'hFFFFFFFE};
    vecs[11] = '{{6'd1, 5'd5, 15'd0, 6'h08},          32'h100,       2'd0, 2'd0, 32'd0,     32'd0,    1'b0, 32'h120,      32'hDEADBEEF, 32'd0,    32'h8};

    reset = 1'b1; stall_d = 1'b0; flush_d = 1'b0; wb_we = 1'b0; wb_addr = '0; wb_data = '0;
    pc_plus_4_f = '0; instr_f = '0; fwd_a_d = '0; fwd_b_d = '0; alu_out_m = '0;
    w_reset = 1'b1; w_stall_d = 1'b0; w_flush_d = 1'b0; w_wb_we = 1'b0; w_wb_addr = '0;
    w_wb_data = '0; w_pc_plus_4_f = '0; w_instr_f = '0; w_fwd_a_d = '0; w_fwd_b_d = '0;
    w_alu_out_m = '0;
    step(); step();

    chk("rst_valid", valid_d, 0);
    chk("rst_instr", instr_d, 0);
    chk("rst_pc4", pc_plus_4_d, 0);
    chk("rst_pcsrc", pcsrc_d, 0);
    chk("rst_rd1", rd1_d, 0);
    chk("rst_rd2", rd2_d, 0);
    chk("rst_pc_next", pc_next_d, 0);
    chk("rst_imm", imm_ext_d, 0);
    reset = 1'b0;

    // Write-first bypass on r5
    load({6'd0, 5'd5, 21'd0}, 32'h0);
    wb_we = 1'b1; wb_addr = 5'd5; wb_data = 32'hDEADBEEF;
    #1 chk("bypass_same_cycle", rd1_d, 32'hDEADBEEF);
    step();
    wb_we = 1'b0;
    #1 chk("bypass_committed", rd1_d, 32'hDEADBEEF);

    // Writes to r0 are discarded, including on the bypass path
    load(32'h0, 32'h0);
    wb_we = 1'b1; wb_addr = 5'd0; wb_data = 32'h1234;
    #1 chk("r0_bypass", rd1_d, 0);
    step();
    wb_we = 1'b0;
    #1 chk("r0_after", rd1_d, 0);

    wb_write(5'd1, 32'd7);

    for (int i = 0; i < NVEC; i++) begin
      load(vecs[i].instr, vecs[i].pc4);
      fwd_a_d = vecs[i].fa; fwd_b_d = vecs[i].fb;
      alu_out_m = vecs[i].alu; wb_data = vecs[i].wbd;
      #1;
      chk($sformatf("vec%0d.valid", i), valid_d, 1);
      chk($sformatf("vec%0d.rs", i), rs_d, vecs[i].instr[25:21]);
      chk($sformatf("vec%0d.rd1", i), rd1_d, vecs[i].exp_rd1);
      chk($sformatf("vec%0d.rd2", i), rd2_d, vecs[i].exp_rd2);
      chk($sformatf("vec%0d.imm", i), imm_ext_d, vecs[i].exp_imm);
      chk($sformatf("vec%0d.pcsrc", i), pcsrc_d, vecs[i].exp_pcsrc);
      chk($sformatf("vec%0d.pc_next", i), pc_next_d, vecs[i].exp_next);
    end
    fwd_a_d = '0; fwd_b_d = '0; alu_out_m = '0; wb_data = '0;

    // jal held by a two-cycle stall, link written when the stall releases
    load(JAL_40, 32'h2004);
    stall_d = 1'b1; instr_f = 32'h0;
    #1 chk("jal_stall_c0.pcsrc", pcsrc_d, 1);
    chk("jal_stall_c0.pc_next", pc_next_d, 32'h100);
    step();
    chk("jal_stall_c1.instr", instr_d, JAL_40);
    chk("jal_stall_c1.pcsrc", pcsrc_d, 1);
    chk("jal_stall_c1.pc_next", pc_next_d, 32'h100);
    step();
    chk("jal_stall_c2.pcsrc", pcsrc_d, 1);
    chk("jal_stall_c2.pc_next", pc_next_d, 32'h100);
    stall_d = 1'b0; instr_f = READ_R31; pc_plus_4_f = 32'h0;
    #1 chk("jal_release.pcsrc", pcsrc_d, 1);
    chk("jal_release.pc_next", pc_next_d, 32'h100);
    step();
    chk("jal_link_r31", rd1_d, 32'h2008);

    // jal whose rs field is r31 exposes any link write during a stall
    wb_write(5'd31, 32'h77);
    load(JAL_RS31, 32'h3000);
    stall_d = 1'b1; instr_f = READ_R31;
    #1 chk("stall_no_link_bypass", rd1_d, 32'h77);
    chk("jal_rs31.pc_next", pc_next_d, 32'h0F800000);
    step();
    chk("stall_no_link_commit", rd1_d, 32'h77);
    stall_d = 1'b0;
    #1 chk("release_link_bypass", rd1_d, 32'h3004);
    step();
    chk("release_link_commit", rd1_d, 32'h3004);

    // Link port wins a same-register collision with writeback
    load(JAL_40, 32'h4000);
    instr_f = READ_R31;
    wb_we = 1'b1; wb_addr = 5'd31; wb_data = 32'h55;
    step();
    wb_we = 1'b0;
    #1 chk("link_beats_wb", rd1_d, 32'h4004);

    // Flush has priority over stall
    load(J_40, 32'hA0002004);
    chk("pre_flush.pcsrc", pcsrc_d, 1);
    flush_d = 1'b1; stall_d = 1'b1;
    step();
    flush_d = 1'b0; stall_d = 1'b0;
    #1 chk("flush_stall.valid", valid_d, 0);
    chk("flush_stall.instr", instr_d, 0);
    chk("flush_stall.pcsrc", pcsrc_d, 0);

    // Reset overrides a stall and discards the concurrent write
    load(J_40, 32'hA0002004);
    stall_d = 1'b1; reset = 1'b1;
    wb_we = 1'b1; wb_addr = 5'd3; wb_data = 32'h99;
    step();
    chk("rst_stall.valid", valid_d, 0);
    chk("rst_stall.instr", instr_d, 0);
    chk("rst_stall.pcsrc", pcsrc_d, 0);
    reset = 1'b0; stall_d = 1'b0; wb_we = 1'b0;
    load({6'd0, 5'd1, 5'd3, 16'd0}, 32'h0);
    chk("rst_clears_r1", rd1_d, 0);
    chk("rst_drops_wb_r3", rd2_d, 0);

    // XLEN=64, NREG=16 instance
    chk("w_rst_valid", w_valid_d, 0);
    chk("w_rst_pc_next", w_pc_next_d, 0);
    w_reset = 1'b0;
    w_load({6'd0, 5'd0, 5'd0, 16'h8000}, 64'h0);
    chk("w_imm_sext", w_imm_ext_d, 64'hFFFFFFFFFFFF8000);
    chk("w_branch_target", w_pc_next_d, 64'hFFFFFFFFFFFE0000);
    chk("w_not_taken", w_pcsrc_d, 0);
    w_wb_write(4'd0, 64'h1234);
    w_wb_write(4'd3, 64'h0000000100000001);
    w_load({6'd0, 5'd19, 5'd16, 16'd0}, 64'h0);
    chk("w_addr_high_bits_rd1", w_rd1_d, 64'h0000000100000001);
    chk("w_r0_reads_zero", w_rd2_d, 0);
    w_load(J_40, 64'hFFFF000010000004);
    chk("w_j.pcsrc", w_pcsrc_d, 1);
    chk("w_j.pc_next", w_pc_next_d, 64'hFFFF000010000100);
    w_wb_write(4'd15, 64'h5);
    w_load(JAL_40, 64'hFFFFFFFFFFFFFFFC);
    chk("w_jal.pc_next", w_pc_next_d, 64'hFFFFFFFFF0000100);
    w_instr_f = READ_R31;
    step();
    chk("w_link_wraps", w_rd1_d, 64'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
